// File: rtl/uart_mem_loader.sv
// Framed UART byte stream to 32-bit RAM word writer.
// Frame: MAGIC, ADDR_LO, ADDR_HI, LEN_LO, LEN_HI, 4*LEN data bytes (little-endian words), CSUM.
module uart_mem_loader #(
   parameter int unsigned MEM_DEPTH      = 17740,
   parameter int unsigned ADDR_W         = 15,
   parameter logic [7:0]  MAGIC          = 8'hA5,
   parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [7:0]        rx_data,
   input  logic              rx_valid,
   output logic              rx_ready,
   output logic [ADDR_W-1:0] mem_address,
   output logic [3:0]        mem_byteenable,
   output logic              mem_chipselect,
   output logic              mem_write,
   output logic [31:0]       mem_writedata,
   output logic              mem_clken,
   output logic              busy,
   output logic              done,
   output logic [1:0]        err,
   output logic [15:0]       words_written
);

   typedef enum logic [3:0] {
      StIdle, StA0, StA1, StL0, StL1, StChk, StData, StWr, StCs, StErr
   } state_e;

   localparam logic [1:0] ErrOk = 2'd0, ErrBounds = 2'd1, ErrCsum = 2'd2, ErrTimeout = 2'd3;

   state_e            state_q, state_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [7:0]        addr_lo_q, addr_lo_d;
   logic              addr_bad_q, addr_bad_d;
   logic [15:0]       rem_q, rem_d;
   logic [1:0]        byte_idx_q, byte_idx_d;
   logic [31:0]       word_q, word_d;
   logic [7:0]        csum_q, csum_d;
   logic [31:0]       tmo_q, tmo_d;

   logic              rx_ready_q, rx_ready_d;
   logic [ADDR_W-1:0] mem_address_q, mem_address_d;
   logic [3:0]        mem_byteenable_q, mem_byteenable_d;
   logic              mem_write_q, mem_write_d;
   logic [31:0]       mem_writedata_q, mem_writedata_d;
   logic              mem_clken_q;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic [1:0]        err_q, err_d;
   logic [15:0]       words_written_q, words_written_d;

   logic              accept;
   logic [15:0]       addr_full;
   logic [16:0]       end_addr;

   assign accept    = rx_valid & rx_ready_q;
   assign addr_full = {rx_data, addr_lo_q};
   // 17-bit so addr + LEN cannot wrap before the bounds compare.
   assign end_addr  = 17'(addr_q) + 17'(rem_q);

   always_comb begin
      state_d         = state_q;
      addr_d          = addr_q;
      addr_lo_d       = addr_lo_q;
      addr_bad_d      = addr_bad_q;
      rem_d           = rem_q;
      byte_idx_d      = byte_idx_q;
      word_d          = word_q;
      csum_d          = csum_q;
      busy_d          = busy_q;
      done_d          = 1'b0;
      err_d           = err_q;
      words_written_d = words_written_q;
      tmo_d           = (state_q == StIdle || accept) ? 32'd0 : tmo_q + 32'd1;

      unique case (state_q)
         StIdle: begin
            if (accept && rx_data == MAGIC) begin
               err_d           = ErrOk;
               words_written_d = 16'd0;
               csum_d          = 8'd0;
               addr_bad_d      = 1'b0;
               busy_d          = 1'b1;
               state_d         = StA0;
            end
         end
         StA0: begin
            if (accept) begin
               addr_lo_d = rx_data;
               state_d   = StA1;
            end
         end
         StA1: begin
            if (accept) begin
               addr_d     = addr_full[ADDR_W-1:0];
               addr_bad_d = (addr_full >> ADDR_W) != 16'd0;
               state_d    = StL0;
            end
         end
         StL0: begin
            if (accept) begin
               rem_d   = {rem_q[15:8], rx_data};
               state_d = StL1;
            end
         end
         StL1: begin
            if (accept) begin
               rem_d   = {rx_data, rem_q[7:0]};
               state_d = StChk;
            end
         end
         StChk: begin
            if (addr_bad_q || end_addr > 17'(MEM_DEPTH)) begin
               err_d   = ErrBounds;
               busy_d  = 1'b0;
               state_d = StErr;
            end else if (rem_q == 16'd0) begin
               state_d = StCs;
            end else begin
               byte_idx_d = 2'd0;
               state_d    = StData;
            end
         end
         StData: begin
            if (accept) begin
               // Shift in from the top so the first byte ends up in [7:0].
               word_d     = {rx_data, word_q[31:8]};
               csum_d     = csum_q + rx_data;
               byte_idx_d = byte_idx_q + 2'd1;
               if (byte_idx_q == 2'd3) state_d = StWr;
            end
         end
         StWr: begin
            addr_d          = addr_q + ADDR_W'(1);
            words_written_d = words_written_q + 16'd1;
            rem_d           = rem_q - 16'd1;
            state_d         = (rem_q == 16'd1) ? StCs : StData;
         end
         StCs: begin
            if (accept) begin
               if (rx_data == csum_q) done_d = 1'b1;
               else                   err_d  = ErrCsum;
               busy_d  = 1'b0;
               state_d = StIdle;
            end
         end
         StErr: begin
            busy_d  = 1'b0;
            state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase

      if (state_q != StIdle && !accept && tmo_q == 32'(TIMEOUT_CYCLES - 1)) begin
         err_d   = ErrTimeout;
         busy_d  = 1'b0;
         done_d  = 1'b0;
         state_d = StIdle;
      end

      // Outputs are registered from the next state so they line up with state_q.
      rx_ready_d       = state_d inside {StIdle, StA0, StA1, StL0, StL1, StData, StCs};
      mem_write_d      = (state_d == StWr);
      mem_byteenable_d = mem_write_d ? 4'hF : 4'h0;
      mem_address_d    = mem_write_d ? addr_d : mem_address_q;
      mem_writedata_d  = mem_write_d ? word_d : mem_writedata_q;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q          <= StIdle;
         addr_q           <= '0;
         addr_lo_q        <= 8'd0;
         addr_bad_q       <= 1'b0;
         rem_q            <= 16'd0;
         byte_idx_q       <= 2'd0;
         word_q           <= 32'd0;
         csum_q           <= 8'd0;
         tmo_q            <= 32'd0;
         rx_ready_q       <= 1'b0;
         mem_address_q    <= '0;
         mem_byteenable_q <= 4'h0;
         mem_write_q      <= 1'b0;
         mem_writedata_q  <= 32'd0;
         mem_clken_q      <= 1'b0;
         busy_q           <= 1'b0;
         done_q           <= 1'b0;
         err_q            <= ErrOk;
         words_written_q  <= 16'd0;
      end else begin
         state_q          <= state_d;
         addr_q           <= addr_d;
         addr_lo_q        <= addr_lo_d;
         addr_bad_q       <= addr_bad_d;
         rem_q            <= rem_d;
         byte_idx_q       <= byte_idx_d;
         word_q           <= word_d;
         csum_q           <= csum_d;
         tmo_q            <= tmo_d;
         rx_ready_q       <= rx_ready_d;
         mem_address_q    <= mem_address_d;
         mem_byteenable_q <= mem_byteenable_d;
         mem_write_q      <= mem_write_d;
         mem_writedata_q  <= mem_writedata_d;
         mem_clken_q      <= 1'b1;
         busy_q           <= busy_d;
         done_q           <= done_d;
         err_q            <= err_d;
         words_written_q  <= words_written_d;
      end
   end

   assign rx_ready       = rx_ready_q;
   assign mem_address    = mem_address_q;
   assign mem_byteenable = mem_byteenable_q;
   assign mem_chipselect = mem_write_q;
   assign mem_write      = mem_write_q;
   assign mem_writedata  = mem_writedata_q;
   assign mem_clken      = mem_clken_q;
   assign busy           = busy_q;
   assign done           = done_q;
   assign err            = err_q;
   assign words_written  = words_written_q;

endmodule

// File: tb/tb_uart_mem_loader.sv
// Randomized self-checking bench for uart_mem_loader against a frame-level reference model.
module tb_uart_mem_loader;

   localparam int unsigned MemDepth = 17740;
   localparam int unsigned AddrW    = 15;
   localparam int unsigned Tmo      = 50;

   typedef logic [7:0] u8;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [7:0]  rx_data = 8'd0;
   logic        rx_valid = 1'b0;
   logic        rx_ready;
   logic [14:0] mem_address;
   logic [3:0]  mem_byteenable;
   logic        mem_chipselect;
   logic        mem_write;
   logic [31:0] mem_writedata;
   logic        mem_clken;
   logic        busy;
   logic        done;
   logic [1:0]  err;
   logic [15:0] words_written;

   always #5 clk = ~clk;

   uart_mem_loader #(
      .MEM_DEPTH(MemDepth),
      .ADDR_W(AddrW),
      .MAGIC(8'hA5),
      .TIMEOUT_CYCLES(Tmo)
   ) dut (
      .clk(clk),
      .reset(reset),
      .rx_data(rx_data),
      .rx_valid(rx_valid),
      .rx_ready(rx_ready),
      .mem_address(mem_address),
      .mem_byteenable(mem_byteenable),
      .mem_chipselect(mem_chipselect),
      .mem_write(mem_write),
      .mem_writedata(mem_writedata),
      .mem_clken(mem_clken),
      .busy(busy),
      .done(done),
      .err(err),
      .words_written(words_written)
   );

   int vec = 0;
   int miss = 0;

   logic [14:0] got_addr[$];
   logic [31:0] got_data[$];
   int          done_cnt = 0;
   logic        prev_wr = 1'b0;

   logic [14:0] exp_addr[$];
   logic [31:0] exp_data[$];
   int          exp_done;
   logic [1:0]  exp_err;
   int          exp_ww;

   // Write/done observer
   always @(negedge clk) begin
      if (mem_write === 1'b1) begin
         got_addr.push_back(mem_address);
         got_data.push_back(mem_writedata);
         vec++;
         if (mem_chipselect !== 1'b1 || mem_byteenable !== 4'hF || prev_wr !== 1'b0) begin
            miss++;
            $display("FAIL wr_strobe: cs=%b be=%h prev_wr=%b, required cs=1 be=f prev_wr=0",
                     mem_chipselect, mem_byteenable, prev_wr);
         end
      end
      prev_wr <= (mem_write === 1'b1);
      if (done === 1'b1) begin
         done_cnt++;
         vec++;
         if (err !== 2'd0) begin
            miss++;
            $display("FAIL done_with_err: err=%0d while done, required 0", err);
         end
      end
   end

   // Reference model: frame bytes -> expected writes and outcome.
   task automatic model(input u8 f[$]);
      int unsigned a, len, sum;
      a   = int'({f[2], f[1]});
      len = int'({f[4], f[3]});
      exp_addr.delete();
      exp_data.delete();
      if (a >= (1 << AddrW) || a + len > MemDepth) begin
         exp_done = 0;
         exp_err  = 2'd1;
         exp_ww   = 0;
         return;
      end
      sum = 0;
      for (int i = 0; i < int'(len); i++) begin
         exp_addr.push_back(15'(a + i));
         exp_data.push_back({f[5+4*i+3], f[5+4*i+2], f[5+4*i+1], f[5+4*i]});
         for (int k = 0; k < 4; k++) sum += f[5+4*i+k];
      end
      exp_ww = int'(len);
      if (u8'(sum % 256) == f[5+4*len]) begin
         exp_done = 1;
         exp_err  = 2'd0;
      end else begin
         exp_done = 0;
         exp_err  = 2'd2;
      end
   endtask

   // Called at a negedge; returns at a negedge after the byte has been accepted.
   task automatic send_byte(input u8 b, input int gap_max);
      int n = 0;
      rx_data  = b;
      rx_valid = 1'b1;
      while (rx_ready !== 1'b1 && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (n >= 20) begin
         vec++;
         miss++;
         $display("FAIL rx_ready_wait: byte %h not accepted within 20 cycles", b);
      end
      @(negedge clk);
      rx_valid = 1'b0;
      repeat ($urandom_range(gap_max, 0)) @(negedge clk);
   endtask

   task automatic send_frame(input u8 f[$]);
      foreach (f[i]) send_byte(f[i], 2);
      repeat (4) @(negedge clk);
   endtask

   task automatic clear_obs();
      got_addr.delete();
      got_data.delete();
      done_cnt = 0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (3) @(negedge clk);
      vec++;
      if ({rx_ready, mem_address, mem_byteenable, mem_chipselect, mem_write, mem_writedata,
           mem_clken, busy, done, err, words_written} !== '0) begin
         miss++;
         $display("FAIL reset_vals: rdy=%b addr=%h be=%h cs=%b wr=%b wd=%h ck=%b busy=%b done=%b err=%0d ww=%0d, required all 0",
                  rx_ready, mem_address, mem_byteenable, mem_chipselect, mem_write,
                  mem_writedata, mem_clken, busy, done, err, words_written);
      end
      reset = 1'b0;
      vec++;
      if (rx_ready !== 1'b0 || mem_clken !== 1'b0) begin
         miss++;
         $display("FAIL reset_release_c1: rdy=%b clken=%b, required 0 0", rx_ready, mem_clken);
      end
      @(negedge clk);
      vec++;
      if (rx_ready !== 1'b1 || mem_clken !== 1'b1 || busy !== 1'b0) begin
         miss++;
         $display("FAIL reset_release_c2: rdy=%b clken=%b busy=%b, required 1 1 0",
                  rx_ready, mem_clken, busy);
      end
   endtask

   task automatic test_basic();
      u8 f[$];
      for (int t = 0; t < 2; t++) begin
         f = '{8'hA5, 8'h10, 8'h00, 8'h02, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44,
               8'h55, 8'h66, 8'h77, 8'h88, 8'h64};
         if (t == 1) f[13] = 8'h00;
         model(f);
         clear_obs();
         send_frame(f);
         vec++;
         if (got_addr.size() != exp_addr.size()) begin
            miss++;
            $display("FAIL basic%0d nwrites: got %0d required %0d", t, got_addr.size(),
                     exp_addr.size());
         end else begin
            foreach (exp_addr[i]) begin
               vec++;
               if (got_addr[i] !== exp_addr[i] || got_data[i] !== exp_data[i]) begin
                  miss++;
                  $display("FAIL basic%0d write%0d: got %h@%h required %h@%h", t, i,
                           got_data[i], got_addr[i], exp_data[i], exp_addr[i]);
               end
            end
         end
         vec++;
         if (done_cnt != exp_done || err !== exp_err || words_written !== 16'(exp_ww)
             || busy !== 1'b0) begin
            miss++;
            $display("FAIL basic%0d status: done=%0d err=%0d ww=%0d busy=%b, required %0d %0d %0d 0",
                     t, done_cnt, err, words_written, busy, exp_done, exp_err, exp_ww);
         end
      end
   endtask

   task automatic test_bounds();
      u8 f[$];
      for (int t = 0; t < 2; t++) begin
         if (t == 0) f = '{8'hA5, 8'h4C, 8'h45, 8'h01, 8'h00};
         else f = '{8'hA5, 8'h4B, 8'h45, 8'h01, 8'h00, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h38};
         model(f);
         clear_obs();
         send_frame(f);
         vec++;
         if (got_addr.size() != exp_addr.size()) begin
            miss++;
            $display("FAIL bounds%0d nwrites: got %0d required %0d", t, got_addr.size(),
                     exp_addr.size());
         end else begin
            foreach (exp_addr[i]) begin
               vec++;
               if (got_addr[i] !== exp_addr[i] || got_data[i] !== exp_data[i]) begin
                  miss++;
                  $display("FAIL bounds%0d write%0d: got %h@%h required %h@%h", t, i,
                           got_data[i], got_addr[i], exp_data[i], exp_addr[i]);
               end
            end
         end
         vec++;
         if (done_cnt != exp_done || err !== exp_err || busy !== 1'b0) begin
            miss++;
            $display("FAIL bounds%0d status: done=%0d err=%0d busy=%b, required %0d %0d 0",
                     t, done_cnt, err, busy, exp_done, exp_err);
         end
      end
   endtask

   task automatic test_zero_len();
      u8 f[$];
      clear_obs();
      send_byte(8'h00, 1);
      send_byte(8'hFF, 1);
      f = '{8'hA5, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
      model(f);
      send_frame(f);
      vec++;
      if (got_addr.size() != 0 || done_cnt != exp_done || err !== exp_err
          || words_written !== 16'd0) begin
         miss++;
         $display("FAIL zero_len: writes=%0d done=%0d err=%0d ww=%0d, required 0 %0d %0d 0",
                  got_addr.size(), done_cnt, err, words_written, exp_done, exp_err);
      end
   endtask

   task automatic test_timeout();
      u8  f[$];
      int k;
      clear_obs();
      f = '{8'hA5, 8'h20, 8'h00, 8'h01, 8'h00, 8'h11, 8'h22};
      foreach (f[i]) send_byte(f[i], 0);
      k = 0;
      while (err !== 2'd3 && k < 60) begin
         @(negedge clk);
         k++;
      end
      vec++;
      if (k != Tmo) begin
         miss++;
         $display("FAIL timeout_cycle: err=3 after %0d cycles, required %0d", k, Tmo);
      end
      vec++;
      if (busy !== 1'b0 || got_addr.size() != 0 || done_cnt != 0) begin
         miss++;
         $display("FAIL timeout_state: busy=%b writes=%0d done=%0d, required 0 0 0",
                  busy, got_addr.size(), done_cnt);
      end
      f = '{8'hA5, 8'h21, 8'h00, 8'h01, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h0A};
      model(f);
      clear_obs();
      send_frame(f);
      vec++;
      if (done_cnt != 1 || err !== 2'd0 || got_addr.size() != 1) begin
         miss++;
         $display("FAIL timeout_recover: done=%0d err=%0d writes=%0d, required 1 0 1",
                  done_cnt, err, got_addr.size());
      end else begin
         vec++;
         if (got_addr[0] !== exp_addr[0] || got_data[0] !== exp_data[0]) begin
            miss++;
            $display("FAIL timeout_recover_wr: got %h@%h required %h@%h",
                     got_data[0], got_addr[0], exp_data[0], exp_addr[0]);
         end
      end
   endtask

   task automatic test_reset_mid();
      u8 f[$];
      clear_obs();
      f = '{8'hA5, 8'h00, 8'h01, 8'h02, 8'h00, 8'hA1, 8'hB2, 8'hC3, 8'hD4,
            8'hE5, 8'hF6, 8'h07, 8'h18, 8'h00};
      for (int i = 0; i < 7; i++) send_byte(f[i], 2);
      rx_data  = f[7];
      rx_valid = 1'b1;
      reset    = 1'b1;
      @(negedge clk);
      vec++;
      if ({rx_ready, mem_address, mem_byteenable, mem_chipselect, mem_write, mem_writedata,
           mem_clken, busy, done, err, words_written} !== '0) begin
         miss++;
         $display("FAIL midreset_vals: rdy=%b wr=%b busy=%b ck=%b ww=%0d, required all 0",
                  rx_ready, mem_write, busy, mem_clken, words_written);
      end
      reset    = 1'b0;
      rx_valid = 1'b0;
      vec++;
      if (rx_ready !== 1'b0) begin
         miss++;
         $display("FAIL midreset_c1: rdy=%b, required 0", rx_ready);
      end
      @(negedge clk);
      vec++;
      if (rx_ready !== 1'b1 || got_addr.size() != 0 || done_cnt != 0) begin
         miss++;
         $display("FAIL midreset_c2: rdy=%b writes=%0d done=%0d, required 1 0 0",
                  rx_ready, got_addr.size(), done_cnt);
      end
      f[13] = 8'hA1 + 8'hB2 + 8'hC3 + 8'hD4 + 8'hE5 + 8'hF6 + 8'h07 + 8'h18;
      model(f);
      clear_obs();
      send_frame(f);
      vec++;
      if (got_addr.size() != 2 || done_cnt != 1 || err !== 2'd0 || words_written !== 16'd2) begin
         miss++;
         $display("FAIL midreset_frame: writes=%0d done=%0d err=%0d ww=%0d, required 2 1 0 2",
                  got_addr.size(), done_cnt, err, words_written);
      end else begin
         foreach (exp_addr[i]) begin
            vec++;
            if (got_addr[i] !== exp_addr[i] || got_data[i] !== exp_data[i]) begin
               miss++;
               $display("FAIL midreset_wr%0d: got %h@%h required %h@%h", i,
                        got_data[i], got_addr[i], exp_data[i], exp_addr[i]);
            end
         end
      end
   endtask

   task automatic test_random();
      u8           f[$];
      u8           g;
      int unsigned len, addr, sum, kind;
      for (int t = 0; t < 12; t++) begin
         clear_obs();
         repeat ($urandom_range(2, 0)) begin
            g = u8'($urandom_range(255, 0));
            if (g == 8'hA5) g = 8'h5A;
            send_byte(g, 1);
         end
         len  = $urandom_range(4, 0);
         kind = $urandom_range(4, 0);
         if (kind == 0) addr = MemDepth - len + 1 + $urandom_range(3, 0);
         else if (kind == 1) addr = MemDepth - len;
         else addr = $urandom_range(MemDepth - len, 0);
         if (kind == 0 && $urandom_range(1, 0) == 1) addr = addr | 32'h8000;
         f = '{8'hA5, u8'(addr), u8'(addr >> 8), u8'(len), 8'h00};
         if (kind != 0) begin
            sum = 0;
            for (int i = 0; i < int'(4 * len); i++) begin
               g = ($urandom_range(7, 0) == 0) ? 8'hA5 : u8'($urandom_range(255, 0));
               f.push_back(g);
               sum += g;
            end
            f.push_back(($urandom_range(3, 0) == 0) ? u8'(sum + 1) : u8'(sum));
         end
         model(f);
         send_frame(f);
         vec++;
         if (got_addr.size() != exp_addr.size()) begin
            miss++;
            $display("FAIL rand%0d nwrites: got %0d required %0d", t, got_addr.size(),
                     exp_addr.size());
         end else begin
            foreach (exp_addr[i]) begin
               vec++;
               if (got_addr[i] !== exp_addr[i] || got_data[i] !== exp_data[i]) begin
                  miss++;
                  $display("FAIL rand%0d write%0d: got %h@%h required %h@%h", t, i,
                           got_data[i], got_addr[i], exp_data[i], exp_addr[i]);
               end
            end
         end
         vec++;
         if (done_cnt != exp_done || err !== exp_err || busy !== 1'b0
             || (exp_err != 2'd1 && words_written !== 16'(exp_ww))) begin
            miss++;
            $display("FAIL rand%0d status: done=%0d err=%0d ww=%0d busy=%b, required %0d %0d %0d 0",
                     t, done_cnt, err, words_written, busy, exp_done, exp_err, exp_ww);
         end
      end
   endtask

   initial begin
      @(negedge clk);
      test_reset();
      test_basic();
      test_bounds();
      test_zero_len();
      test_timeout();
      test_reset_mid();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
      $finish;
   end

endmodule
